// File: rtl/fp_add_pkg.sv
// rtl/fp_add_pkg.sv - shared constants and state encoding for the FP adder return path
package fp_add_pkg;

    localparam int WIDTH = 11;
    localparam int EXP_W = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        NORM    = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/tc_to_signmag_norm_if.sv
// rtl/tc_to_signmag_norm_if.sv - input/output handshake bundle of the sign-magnitude normalizer
interface tc_to_signmag_norm_if #(
    parameter int WIDTH = fp_add_pkg::WIDTH,
    parameter int EXP_W = fp_add_pkg::EXP_W
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_sum;
    logic [EXP_W-1:0] in_exp;
    logic             out_valid;
    logic             out_ready;
    logic             out_sign;
    logic [WIDTH-1:0] out_mag;
    logic [EXP_W-1:0] out_exp;
    logic             out_zero;
    logic             out_underflow;

    modport slave (
        input  in_valid, in_sum, in_exp, out_ready,
        output in_ready, out_valid, out_sign, out_mag, out_exp, out_zero, out_underflow
    );

    modport master (
        output in_valid, in_sum, in_exp, out_ready,
        input  in_ready, out_valid, out_sign, out_mag, out_exp, out_zero, out_underflow
    );

endinterface

// File: rtl/tc_magnitude.sv
// rtl/tc_magnitude.sv - two's-complement value to sign and unsigned magnitude
module tc_magnitude #(
    parameter int WIDTH = fp_add_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] sum,
    output logic             sign,
    output logic [WIDTH-1:0] mag
);

    // The most negative input maps onto itself, which read unsigned is its true magnitude.
    assign sign = sum[WIDTH-1];
    assign mag  = sign ? (~sum + {{(WIDTH-1){1'b0}}, 1'b1}) : sum;

endmodule

// File: rtl/tc_to_signmag_norm.sv
// rtl/tc_to_signmag_norm.sv - mantissa sum to sign/magnitude with one-bit-per-cycle normalization
module tc_to_signmag_norm #(
    parameter int WIDTH = fp_add_pkg::WIDTH,
    parameter int EXP_W = fp_add_pkg::EXP_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    tc_to_signmag_norm_if.slave   bus
);

    import fp_add_pkg::*;

    state_t           state_q, state_d;
    logic             sign_q;
    logic [WIDTH-1:0] mag_q;
    logic [EXP_W-1:0] exp_q;
    logic             zero_q;
    logic             uf_q;
    logic             cv_sign;
    logic [WIDTH-1:0] cv_mag;

    tc_magnitude #(.WIDTH(WIDTH)) u_mag (
        .sum  (mag_q),
        .sign (cv_sign),
        .mag  (cv_mag)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_d = CONVERT;
            end
            CONVERT: state_d = NORM;
            NORM: begin
                if (mag_q == '0 || mag_q[WIDTH-1] || exp_q == '0) state_d = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // mag_q holds the raw sum until CONVERT replaces it with its magnitude.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q <= 1'b0;
            mag_q  <= '0;
            exp_q  <= '0;
            zero_q <= 1'b0;
            uf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        sign_q <= 1'b0;
                        mag_q  <= bus.in_sum;
                        exp_q  <= bus.in_exp;
                        zero_q <= 1'b0;
                        uf_q   <= 1'b0;
                    end
                end
                CONVERT: begin
                    sign_q <= cv_sign;
                    mag_q  <= cv_mag;
                end
                NORM: begin
                    if (mag_q == '0) begin
                        zero_q <= 1'b1;
                        exp_q  <= '0;
                        sign_q <= 1'b0;
                    end else if (!mag_q[WIDTH-1]) begin
                        if (exp_q == '0) begin
                            uf_q <= 1'b1;
                        end else begin
                            mag_q <= {mag_q[WIDTH-2:0], 1'b0};
                            exp_q <= exp_q - 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.out_sign      = sign_q;
    assign bus.out_mag       = mag_q;
    assign bus.out_exp       = exp_q;
    assign bus.out_zero      = zero_q;
    assign bus.out_underflow = uf_q;

endmodule
